// File: rtl/dot_scan_controller.sv
// Raster scan controller: walks a row/column dot array, dwelling on each addressed
// dot and driving fire_out from the downstream sequencer's pattern bits.
module dot_scan_controller #(
    parameter int MEM_LENGTH         = 48,
    parameter int MEM_ADDRESS_LENGTH = 6,
    parameter int DWELL_WIDTH        = 16
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          start,
    input  logic                          abort,
    input  logic                          continuous,
    input  logic                          scan_by_col,
    input  logic [DWELL_WIDTH-1:0]        dwell_cycles,
    input  logic [MEM_ADDRESS_LENGTH-1:0] last_row,
    input  logic [MEM_ADDRESS_LENGTH-1:0] last_col,
    input  logic                          firing_data,
    input  logic                          firing_bit,
    output logic [MEM_ADDRESS_LENGTH-1:0] row_select,
    output logic [MEM_ADDRESS_LENGTH-1:0] col_select,
    output logic                          row_col_select,
    output logic                          fire_out,
    output logic                          busy,
    output logic                          frame_done,
    output logic [7:0]                    frame_count
);

    localparam logic [MEM_ADDRESS_LENGTH-1:0] MAX_IDX  = MEM_ADDRESS_LENGTH'(MEM_LENGTH - 1);
    localparam logic [MEM_ADDRESS_LENGTH-1:0] ONE_IDX  = MEM_ADDRESS_LENGTH'(1);
    localparam logic [DWELL_WIDTH-1:0]        ONE_DWELL = DWELL_WIDTH'(1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETTLE = 2'd1,
        S_FIRE   = 2'd2,
        S_NEXT   = 2'd3
    } state_t;

    state_t r_state;
    state_t w_next_state;

    logic [DWELL_WIDTH-1:0]        r_dwell;
    logic [DWELL_WIDTH-1:0]        r_dwell_cnt;
    logic [MEM_ADDRESS_LENGTH-1:0] r_last_row;
    logic [MEM_ADDRESS_LENGTH-1:0] r_last_col;
    logic                          r_scan_by_col;
    logic [MEM_ADDRESS_LENGTH-1:0] r_row;
    logic [MEM_ADDRESS_LENGTH-1:0] r_col;
    logic                          r_fire;
    logic                          r_frame_done;
    logic [7:0]                    r_frame_count;

    logic [DWELL_WIDTH-1:0]        w_dwell_eff;
    logic                          w_dwell_done;
    logic                          w_last_dot;
    logic [MEM_ADDRESS_LENGTH-1:0] w_last_row_clamped;
    logic [MEM_ADDRESS_LENGTH-1:0] w_last_col_clamped;

    assign w_dwell_eff        = (r_dwell == '0) ? ONE_DWELL : r_dwell;
    assign w_dwell_done       = (r_dwell_cnt >= w_dwell_eff);
    assign w_last_dot         = (r_row == r_last_row) && (r_col == r_last_col);
    assign w_last_row_clamped = (last_row > MAX_IDX) ? MAX_IDX : last_row;
    assign w_last_col_clamped = (last_col > MAX_IDX) ? MAX_IDX : last_col;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        if (abort) begin
            w_next_state = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:   if (start) w_next_state = S_SETTLE;
                S_SETTLE: w_next_state = S_FIRE;
                S_FIRE:   if (w_dwell_done) w_next_state = S_NEXT;
                S_NEXT: begin
                    if (w_last_dot && !continuous) w_next_state = S_IDLE;
                    else                           w_next_state = S_SETTLE;
                end
                default:  w_next_state = S_IDLE;
            endcase
        end
    end

    // Config is reloaded both at start and at each continuous frame boundary,
    // so mid-frame input changes only take effect on the following frame.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_dwell       <= '0;
            r_dwell_cnt   <= '0;
            r_last_row    <= '0;
            r_last_col    <= '0;
            r_scan_by_col <= 1'b0;
            r_row         <= '0;
            r_col         <= '0;
            r_fire        <= 1'b0;
            r_frame_done  <= 1'b0;
            r_frame_count <= '0;
        end else if (abort) begin
            r_row        <= '0;
            r_col        <= '0;
            r_fire       <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_dwell       <= dwell_cycles;
                        r_last_row    <= w_last_row_clamped;
                        r_last_col    <= w_last_col_clamped;
                        r_scan_by_col <= scan_by_col;
                        r_row         <= '0;
                        r_col         <= '0;
                    end
                end
                S_SETTLE: begin
                    r_fire      <= firing_bit & firing_data;
                    r_dwell_cnt <= ONE_DWELL;
                end
                S_FIRE: begin
                    if (w_dwell_done) r_fire <= 1'b0;
                    else              r_dwell_cnt <= r_dwell_cnt + ONE_DWELL;
                end
                S_NEXT: begin
                    if (w_last_dot) begin
                        r_frame_done  <= 1'b1;
                        r_frame_count <= r_frame_count + 8'd1;
                        r_row         <= '0;
                        r_col         <= '0;
                        if (continuous) begin
                            r_dwell       <= dwell_cycles;
                            r_last_row    <= w_last_row_clamped;
                            r_last_col    <= w_last_col_clamped;
                            r_scan_by_col <= scan_by_col;
                        end
                    end else if (r_col < r_last_col) begin
                        r_col <= r_col + ONE_IDX;
                    end else begin
                        r_col <= '0;
                        r_row <= r_row + ONE_IDX;
                    end
                end
                default: r_fire <= 1'b0;
            endcase
        end
    end

    assign row_select     = r_row;
    assign col_select     = r_col;
    assign row_col_select = r_scan_by_col;
    assign fire_out       = r_fire;
    assign busy           = (r_state != S_IDLE);
    assign frame_done     = r_frame_done;
    assign frame_count    = r_frame_count;

endmodule

// File: tb/tb_dot_scan_controller.sv
// Directed bench for dot_scan_controller: table of single-frame scenarios plus
// hand-written sequences for dot order, pattern masking, abort, reset and wrap.
module tb_dot_scan_controller;

    localparam int AW = 6;
    localparam int DW = 16;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic          continuous = 1'b0;
    logic          scan_by_col = 1'b0;
    logic [DW-1:0] dwell_cycles = '0;
    logic [AW-1:0] last_row = '0;
    logic [AW-1:0] last_col = '0;
    logic          firing_data;
    logic          firing_bit = 1'b1;
    logic          pattern_en = 1'b0;

    logic [AW-1:0] row_select;
    logic [AW-1:0] col_select;
    logic          row_col_select;
    logic          fire_out;
    logic          busy;
    logic          frame_done;
    logic [7:0]    frame_count;

    int            checks = 0;
    int            errors = 0;
    logic [7:0]    exp_count = '0;

    dot_scan_controller #(
        .MEM_LENGTH        (48),
        .MEM_ADDRESS_LENGTH(AW),
        .DWELL_WIDTH       (DW)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .start         (start),
        .abort         (abort),
        .continuous    (continuous),
        .scan_by_col   (scan_by_col),
        .dwell_cycles  (dwell_cycles),
        .last_row      (last_row),
        .last_col      (last_col),
        .firing_data   (firing_data),
        .firing_bit    (firing_bit),
        .row_select    (row_select),
        .col_select    (col_select),
        .row_col_select(row_col_select),
        .fire_out      (fire_out),
        .busy          (busy),
        .frame_done    (frame_done),
        .frame_count   (frame_count)
    );

    always #5 clock = ~clock;

    // Downstream sequencer stand-in: pattern bit is 0 only at cell (0,1) when enabled.
    always_comb begin
        firing_data = 1'b1;
        if (pattern_en && row_select == 6'd0 && col_select == 6'd1) firing_data = 1'b0;
    end

    typedef struct {
        logic [DW-1:0] dwell;
        logic [AW-1:0] lr;
        logic [AW-1:0] lc;
        logic          sbc;
        int            exp_len;
        int            exp_fire;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic start_frame(input logic [DW-1:0] d, input logic [AW-1:0] lr,
                               input logic [AW-1:0] lc, input logic sbc);
        @(negedge clock);
        dwell_cycles = d;
        last_row     = lr;
        last_col     = lc;
        scan_by_col  = sbc;
        start        = 1'b1;
        @(posedge clock);
        #1 start = 1'b0;
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int done_at = -1;
        int fires   = 0;
        int pulses  = 0;
        start_frame(v.dwell, v.lr, v.lc, v.sbc);
        for (int c = 0; c < v.exp_len + 4; c++) begin
            @(negedge clock);
            if (c == 0) check($sformatf("v%0d_rcs", idx), 32'(row_col_select), 32'(v.sbc));
            if (fire_out) fires++;
            if (frame_done) begin
                pulses++;
                if (done_at < 0) done_at = c;
            end
        end
        exp_count = exp_count + 8'd1;
        check($sformatf("v%0d_len", idx), 32'(done_at), 32'(v.exp_len));
        check($sformatf("v%0d_fire", idx), 32'(fires), 32'(v.exp_fire));
        check($sformatf("v%0d_pulses", idx), 32'(pulses), 32'd1);
        check($sformatf("v%0d_busy", idx), 32'(busy), 32'd0);
        check($sformatf("v%0d_count", idx), 32'(frame_count), 32'(exp_count));
    endtask

    initial begin
        logic       exp_fire_pat [6];
        logic [7:0] fc_before;
        int         pulses;

        vecs[0] = '{dwell: 16'd3, lr: 6'd1,  lc: 6'd2,  sbc: 1'b0, exp_len: 30,   exp_fire: 18};
        vecs[1] = '{dwell: 16'd0, lr: 6'd0,  lc: 6'd0,  sbc: 1'b1, exp_len: 3,    exp_fire: 1};
        vecs[2] = '{dwell: 16'd1, lr: 6'd0,  lc: 6'd3,  sbc: 1'b0, exp_len: 12,   exp_fire: 4};
        vecs[3] = '{dwell: 16'd2, lr: 6'd2,  lc: 6'd0,  sbc: 1'b1, exp_len: 12,   exp_fire: 6};
        vecs[4] = '{dwell: 16'd5, lr: 6'd0,  lc: 6'd1,  sbc: 1'b0, exp_len: 14,   exp_fire: 10};
        vecs[5] = '{dwell: 16'd1, lr: 6'd50, lc: 6'd1,  sbc: 1'b0, exp_len: 288,  exp_fire: 96};
        vecs[6] = '{dwell: 16'd0, lr: 6'd63, lc: 6'd63, sbc: 1'b1, exp_len: 6912, exp_fire: 2304};

        #1 reset = 1'b1;
        #1;
        check("rst_row", 32'(row_select), 32'd0);
        check("rst_col", 32'(col_select), 32'd0);
        check("rst_rcs", 32'(row_col_select), 32'd0);
        check("rst_fire", 32'(fire_out), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(frame_done), 32'd0);
        check("rst_count", 32'(frame_count), 32'd0);
        @(negedge clock);
        reset = 1'b0;

        for (int i = 0; i < 7; i++) run_vec(i, vecs[i]);

        // Dot order, per-dot pattern masking, and config changes ignored mid-frame
        exp_fire_pat = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        pattern_en = 1'b1;
        pulses = 0;
        start_frame(16'd3, 6'd1, 6'd2, 1'b0);
        dwell_cycles = 16'd9;
        last_row     = 6'd3;
        last_col     = 6'd5;
        for (int c = 0; c < 34; c++) begin
            @(negedge clock);
            if (frame_done) pulses++;
            if (c < 30) begin
                if (c % 5 == 2) begin
                    check($sformatf("seq_row_d%0d", c / 5), 32'(row_select), 32'(c / 15));
                    check($sformatf("seq_col_d%0d", c / 5), 32'(col_select), 32'((c / 5) % 3));
                    check($sformatf("seq_fire_d%0d", c / 5), 32'(fire_out), 32'(exp_fire_pat[c / 5]));
                end
                if (c % 5 == 4) check($sformatf("seq_next_d%0d", c / 5), 32'(fire_out), 32'd0);
            end
            if (c == 30) begin
                check("seq_done_c30", 32'(frame_done), 32'd1);
                check("seq_idle_c30", 32'(busy), 32'd0);
            end
        end
        exp_count = exp_count + 8'd1;
        check("seq_pulses", 32'(pulses), 32'd1);
        check("seq_count", 32'(frame_count), 32'(exp_count));
        pattern_en = 1'b0;

        // Abort in FIRE of dot (0,5) with start also asserted
        fc_before = frame_count;
        start_frame(16'd3, 6'd1, 6'd7, 1'b0);
        for (int c = 0; c < 28; c++) @(negedge clock);
        check("abt_pre_col", 32'(col_select), 32'd5);
        check("abt_pre_fire", 32'(fire_out), 32'd1);
        abort = 1'b1;
        start = 1'b1;
        @(posedge clock);
        #1;
        abort = 1'b0;
        start = 1'b0;
        @(negedge clock);
        check("abt_busy", 32'(busy), 32'd0);
        check("abt_fire", 32'(fire_out), 32'd0);
        check("abt_row", 32'(row_select), 32'd0);
        check("abt_col", 32'(col_select), 32'd0);
        check("abt_done", 32'(frame_done), 32'd0);
        pulses = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clock);
            if (frame_done || busy) pulses++;
        end
        check("abt_quiet", 32'(pulses), 32'd0);
        check("abt_count", 32'(frame_count), 32'(fc_before));

        // Asynchronous reset mid-frame
        start_frame(16'd3, 6'd2, 6'd2, 1'b1);
        for (int c = 0; c < 7; c++) @(negedge clock);
        #2 reset = 1'b1;
        #1;
        check("amr_row", 32'(row_select), 32'd0);
        check("amr_col", 32'(col_select), 32'd0);
        check("amr_rcs", 32'(row_col_select), 32'd0);
        check("amr_fire", 32'(fire_out), 32'd0);
        check("amr_busy", 32'(busy), 32'd0);
        check("amr_count", 32'(frame_count), 32'd0);
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        check("amr_stay_idle", 32'(busy), 32'd0);

        // Continuous mode: 256 frames wrap the counter back to 0
        continuous = 1'b1;
        pulses = 0;
        start_frame(16'd0, 6'd0, 6'd0, 1'b0);
        for (int c = 0; c < 800; c++) begin
            @(negedge clock);
            if (frame_done) begin
                pulses++;
                if (pulses == 255) begin
                    check("cont_count_255", 32'(frame_count), 32'd255);
                    continuous = 1'b0;
                end
            end
        end
        check("cont_pulses", 32'(pulses), 32'd256);
        check("cont_wrap", 32'(frame_count), 32'd0);
        check("cont_idle", 32'(busy), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
